// File: rtl/demux_pkg.sv
// Shared constants and types for the 1-to-4 demultiplexer slice.
// Channel indices double as out_valid/out_ready bit positions.
package demux_pkg;

    localparam int NUM_CH = 4;
    localparam int SEL_W  = 2;

    typedef logic [SEL_W-1:0] sel_t;

    localparam sel_t CH_A = 2'd0;
    localparam sel_t CH_B = 2'd1;
    localparam sel_t CH_C = 2'd2;
    localparam sel_t CH_D = 2'd3;

    function automatic logic [NUM_CH-1:0] sel_onehot(input sel_t s);
        logic [NUM_CH-1:0] oh;
        oh    = '0;
        oh[s] = 1'b1;
        return oh;
    endfunction

endpackage

// File: rtl/demux_slot.sv
// One output channel: single-entry holding register, valid flag and accept counter.
// The data register keeps its last value after a pop; only valid clears.
module demux_slot #(
    parameter int WIDTH = 4,
    parameter int CNT_W = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load,
    input  logic             pop,
    input  logic [WIDTH-1:0] data,
    output logic [WIDTH-1:0] q,
    output logic             valid,
    output logic [CNT_W-1:0] count
);

    always_ff @(posedge clk) begin
        if (reset) begin
            q     <= '0;
            valid <= 1'b0;
            count <= '0;
        end else begin
            if (load) begin
                q     <= data;
                count <= count + CNT_W'(1);
            end
            // A load in the same cycle as a pop keeps the channel full.
            valid <= load | (valid & ~pop);
        end
    end

endmodule

// File: rtl/demux_1to4.sv
// Routes one input word to one of four single-entry output channels selected by sel.
// Holds the select decode and the upstream ready; per-channel state lives in demux_slot.
module demux_1to4
    import demux_pkg::*;
#(
    parameter int WIDTH = 4,
    parameter int CNT_W = 4
) (
    input  logic              clk1,
    input  logic              reset,
    input  logic [WIDTH-1:0]  in_data,
    input  logic              in_valid,
    input  sel_t              sel,
    output logic              in_ready,
    output logic [WIDTH-1:0]  out_a,
    output logic [WIDTH-1:0]  out_b,
    output logic [WIDTH-1:0]  out_c,
    output logic [WIDTH-1:0]  out_d,
    output logic [NUM_CH-1:0] out_valid,
    input  logic [NUM_CH-1:0] out_ready,
    output logic [CNT_W-1:0]  count_a,
    output logic [CNT_W-1:0]  count_b,
    output logic [CNT_W-1:0]  count_c,
    output logic [CNT_W-1:0]  count_d
);

    // Handshake: a word moves when valid && ready on a rising edge. in_ready is a
    // function of sel, out_valid and out_ready only, never of in_valid; upstream must
    // hold in_data/sel while in_valid=1 and in_ready=0.
    logic              accept;
    logic [NUM_CH-1:0] load;
    logic [NUM_CH-1:0] pop;
    logic [WIDTH-1:0]  slot_q   [NUM_CH];
    logic [CNT_W-1:0]  slot_cnt [NUM_CH];

    assign in_ready = !out_valid[sel] || out_ready[sel];
    assign accept   = in_valid && in_ready;
    assign load     = accept ? sel_onehot(sel) : '0;
    assign pop      = out_valid & out_ready;

    for (genvar i = 0; i < NUM_CH; i++) begin : g_slot
        demux_slot #(
            .WIDTH(WIDTH),
            .CNT_W(CNT_W)
        ) u_slot (
            .clk   (clk1),
            .reset (reset),
            .load  (load[i]),
            .pop   (pop[i]),
            .data  (in_data),
            .q     (slot_q[i]),
            .valid (out_valid[i]),
            .count (slot_cnt[i])
        );
    end

    assign out_a   = slot_q[CH_A];
    assign out_b   = slot_q[CH_B];
    assign out_c   = slot_q[CH_C];
    assign out_d   = slot_q[CH_D];
    assign count_a = slot_cnt[CH_A];
    assign count_b = slot_cnt[CH_B];
    assign count_c = slot_cnt[CH_C];
    assign count_d = slot_cnt[CH_D];

endmodule

// File: tb/tb_demux_1to4.sv
// Directed bench for demux_1to4: linear steps with hand-computed expectations.
module tb_demux_1to4;

    logic       clk1 = 1'b0;
    logic       reset;
    logic [3:0] in_data;
    logic       in_valid;
    logic [1:0] sel;
    logic       in_ready;
    logic [3:0] out_a, out_b, out_c, out_d;
    logic [3:0] out_valid;
    logic [3:0] out_ready;
    logic [3:0] count_a, count_b, count_c, count_d;

    int compared   = 0;
    int mismatched = 0;

    always #5 clk1 = ~clk1;

    demux_1to4 #(.WIDTH(4), .CNT_W(4)) dut (
        .clk1      (clk1),
        .reset     (reset),
        .in_data   (in_data),
        .in_valid  (in_valid),
        .sel       (sel),
        .in_ready  (in_ready),
        .out_a     (out_a),
        .out_b     (out_b),
        .out_c     (out_c),
        .out_d     (out_d),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .count_a   (count_a),
        .count_b   (count_b),
        .count_c   (count_c),
        .count_d   (count_d)
    );

    task automatic tick();
        @(posedge clk1);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_all_clear(input string tag);
        check({tag, "_valid"}, 32'(out_valid), 32'h0);
        check({tag, "_outs"}, {16'h0, out_a, out_b, out_c, out_d}, 32'h0);
        check({tag, "_cnts"}, {16'h0, count_a, count_b, count_c, count_d}, 32'h0);
    endtask

    task automatic send(input logic [1:0] s, input logic [3:0] d);
        sel = s; in_data = d; in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
    endtask

    initial begin
        reset = 1'b1; in_data = '0; in_valid = 1'b0; sel = '0; out_ready = '0;
        tick();
        check("ready_in_reset", 32'(in_ready), 32'h1);
        tick();
        reset = 1'b0;
        check_all_clear("reset");

        // single word into channel a
        sel = 2'd0; in_data = 4'b1000; in_valid = 1'b1;
        check("a_ready", 32'(in_ready), 32'h1);
        tick();
        in_valid = 1'b0;
        check("a_data", 32'(out_a), 32'h8);
        check("a_valid", 32'(out_valid), 32'h1);
        check("a_count", 32'(count_a), 32'h1);

        // fill all four channels
        reset = 1'b1; tick(); reset = 1'b0;
        send(2'd0, 4'b1000);
        send(2'd1, 4'b1010);
        send(2'd2, 4'b0001);
        send(2'd3, 4'b1111);
        check("fill_valid", 32'(out_valid), 32'hF);
        check("fill_outs", {16'h0, out_a, out_b, out_c, out_d}, 32'h8A1F);
        check("fill_cnts", {16'h0, count_a, count_b, count_c, count_d}, 32'h1111);

        // full channel c blocks a fifth word
        sel = 2'd2; in_data = 4'b0101; in_valid = 1'b1;
        #1;
        check("c_full_ready", 32'(in_ready), 32'h0);
        tick();
        in_valid = 1'b0;
        check("c_hold", 32'(out_c), 32'h1);
        check("c_hold_cnt", 32'(count_c), 32'h1);
        check("c_hold_valid", 32'(out_valid), 32'hF);

        // pop and load of b on the same edge
        sel = 2'd1; in_data = 4'b0110; in_valid = 1'b1; out_ready = 4'b0010;
        #1;
        check("b_pl_ready", 32'(in_ready), 32'h1);
        tick();
        in_valid = 1'b0; out_ready = 4'b0000;
        check("b_pl_data", 32'(out_b), 32'h6);
        check("b_pl_valid", 32'(out_valid), 32'hF);
        check("b_pl_cnt", 32'(count_b), 32'h2);

        // pop a: valid clears, data and count retained
        out_ready = 4'b0001;
        tick();
        check("a_pop_valid", 32'(out_valid), 32'hE);
        check("a_pop_data", 32'(out_a), 32'h8);
        check("a_pop_cnt", 32'(count_a), 32'h1);
        // ready on an empty channel is ignored
        tick();
        out_ready = 4'b0000;
        check("a_empty_ready", 32'(out_valid), 32'hE);

        // 16 back-to-back words into d with the consumer always ready
        reset = 1'b1; tick(); reset = 1'b0;
        out_ready = 4'b1000; sel = 2'd3; in_valid = 1'b1;
        for (int i = 0; i < 16; i++) begin
            in_data = 4'(i);
            #1;
            check($sformatf("d_ready_%0d", i), 32'(in_ready), 32'h1);
            tick();
            if (i == 14) check("d_cnt_15", 32'(count_d), 32'hF);
        end
        in_valid = 1'b0;
        check("d_cnt_wrap", 32'(count_d), 32'h0);
        check("d_last", 32'(out_d), 32'hF);
        check("d_valid", 32'(out_valid), 32'h8);
        tick();
        out_ready = 4'b0000;
        check("d_drained", 32'(out_valid), 32'h0);

        // reset with a and c full discards everything, including a concurrent accept
        send(2'd0, 4'b0011);
        send(2'd2, 4'b1001);
        check("ac_valid", 32'(out_valid), 32'h5);
        reset = 1'b1; sel = 2'd1; in_data = 4'b0111; in_valid = 1'b1;
        #1;
        check("rst_ready", 32'(in_ready), 32'h1);
        tick();
        reset = 1'b0; in_valid = 1'b0;
        check_all_clear("rst_mid");

        // sel/in_data wiggle with in_valid low has no effect
        send(2'd1, 4'b1100);
        for (int i = 0; i < 8; i++) begin
            sel = 2'(i); in_data = 4'($urandom_range(0, 15));
            #1;
            check($sformatf("idle_ready_%0d", i), 32'(in_ready), (i % 4 == 1) ? 32'h0 : 32'h1);
            tick();
            check($sformatf("idle_state_%0d", i),
                  {12'h0, out_valid, out_b, count_a, count_b, count_c, count_d},
                  {12'h0, 4'b0010, 4'hC, 16'h0100});
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
